// File: rtl/dmem_lsu.sv
// Load/store initiator for four byte-lane dmem banks with a one-deep response buffer.
// Define DMEM_LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module dmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misalign;
  logic        req_err;
  logic        we_p0;
  logic [2:0]  f3_p0;
  logic [1:0]  off_p0;
  logic        err_p0;
  logic [31:0] live_rdata;
  logic [31:0] cap_rdata;
  logic        cap_err;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) bad = f3[2] | (f3[1:0] == 2'b11);
    else    bad = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    return bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                    ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err     = funct3_illegal(req_we, req_funct3) | misalign;
  assign accept      = req_valid & req_ready;
  assign mem_addr    = req_addr;
  assign mem_wr_data = store_data(req_funct3, req_wdata);
  assign mem_we      = (accept & req_we & ~req_err) ? store_mask(req_funct3, req_addr[1:0]) : 4'b0000;

  // Stage p0: request attributes held for the completion cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0  <= req_we;
      f3_p0  <= req_funct3;
      off_p0 <= req_addr[1:0];
      err_p0 <= req_err;
    end
  end

  assign live_rdata = (we_p0 | err_p0) ? 32'd0 : format_load(f3_p0, off_p0, mem_rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_rdata <= 32'd0;
      cap_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RESP && !resp_ready) begin
        cap_rdata <= live_rdata;
        cap_err   <= err_p0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = live_rdata;
        resp_err   = err_p0;
        req_ready  = rst_n & resp_ready;
        if (resp_ready) state_nxt = req_valid ? RESP : IDLE;
        else            state_nxt = HOLD;
      end
      HOLD: begin
        resp_valid = 1'b1;
        resp_rdata = cap_rdata;
        resp_err   = cap_err;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-addressed reference memory plus a queue of expected completions.
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_we;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Four byte-wide banks with registered read
  logic [7:0]  bank [4][16];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) bank[i][mem_addr[5:2]] <= mem_wr_data[8*i +: 8];
    rd_q <= {bank[3][mem_addr[5:2]], bank[2][mem_addr[5:2]],
             bank[1][mem_addr[5:2]], bank[0][mem_addr[5:2]]};
  end
  assign mem_rd_data = rd_q;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [7:0] ref_mem [64];
  resp_t      q[$];
  bit         stalled = 1'b0;
  int         n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    bit e;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e = !legal;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    if (!e && (int'(a[1:0]) % acc_size(f3)) != 0) e = 1'b1;
`else
    if (a[31] === 1'bx) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int base_of(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    return (int'(a[5:0]) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz, base;
    sz = acc_size(f3);
    base = base_of(f3, a);
    v = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // Compare all outputs for this cycle against the model, then advance the model
  task automatic check_cycle();
    logic        exp_rdy, acc, err;
    logic [3:0]  exp_we;
    int          sz, base;
    resp_t       r;
    exp_rdy = rst_n && (q.size() == 0 || (!stalled && resp_ready));
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("resp_rdata", resp_rdata, q[0].rdata);
      check_eq("resp_err", 32'(resp_err), 32'(q[0].err));
    end
    acc = req_valid && exp_rdy;
    err = is_err(req_we, req_funct3, req_addr);
    sz = acc_size(req_funct3);
    base = base_of(req_funct3, req_addr);
    exp_we = 4'b0000;
    if (acc && req_we && !err)
      for (int k = 0; k < sz; k++) exp_we[(base + k) % 4] = 1'b1;
    check_eq("mem_we", 32'(mem_we), 32'(exp_we));
    if (acc && req_we && !err)
      for (int k = 0; k < sz; k++)
        check_eq("wr_lane", 32'(mem_wr_data[8*((base + k) % 4) +: 8]), 32'(req_wdata[8*k +: 8]));
    if (q.size() != 0) begin
      if (resp_ready) begin
        void'(q.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    if (acc) begin
      r.err = err;
      r.rdata = (err || req_we) ? 32'd0 : model_load(req_funct3, req_addr);
      if (req_we && !err)
        for (int k = 0; k < sz; k++) ref_mem[base + k] = req_wdata[8*k +: 8];
      q.push_back(r);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic rr);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; resp_ready = rr;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;

    // Reset values with a store request presented
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'h12345678;
    resp_ready = 1'b1;
    #12;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill every word with known data
    for (int w = 0; w < 16; w++) step(1'b1, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b1);

    step(1'b1, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1);
    check_eq("lw_0x04", resp_rdata, 32'hDEADBEEF);
    check_eq("lw_0x04_err", 32'(resp_err), 32'd0);

    step(1'b1, 1'b1, 3'd0, 32'h0B, 32'h00000080, 1'b1);
    step(1'b1, 1'b0, 3'd0, 32'h0B, 32'h0, 1'b1);
    check_eq("lb_0x0b", resp_rdata, 32'hFFFFFF80);
    step(1'b1, 1'b0, 3'd4, 32'h0B, 32'h0, 1'b1);
    check_eq("lbu_0x0b", resp_rdata, 32'h00000080);

    step(1'b1, 1'b1, 3'd1, 32'h06, 32'h00008001, 1'b1);
    step(1'b1, 1'b0, 3'd1, 32'h06, 32'h0, 1'b1);
    check_eq("lh_0x06", resp_rdata, 32'hFFFF8001);
    step(1'b1, 1'b0, 3'd5, 32'h06, 32'h0, 1'b1);
    check_eq("lhu_0x06", resp_rdata, 32'h00008001);

    // Stalled consumer with a second load waiting
    step(1'b1, 1'b0, 3'd2, 32'h00, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd2, 32'h08 + 32'(i * 4), 32'h0, 1'b0);
    step(1'b1, 1'b0, 3'd2, 32'h08, 32'h0, 1'b1);
    step(1'b1, 1'b0, 3'd2, 32'h08, 32'h0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    step(1'b1, 1'b0, 3'd2, 32'h05, 32'h0, 1'b1);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    check_eq("lw_0x05", resp_rdata, 32'h0);
    check_eq("lw_0x05_err", 32'(resp_err), 32'd1);
`else
    check_eq("lw_0x05", resp_rdata, 32'h8001BEEF);
    check_eq("lw_0x05_err", 32'(resp_err), 32'd0);
`endif
    step(1'b1, 1'b1, 3'd2, 32'h05, 32'hA5A5A5A5, 1'b1);
    step(1'b1, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1);

    // Reset while a completion is outstanding, with a store presented
    step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
    q.delete();
    stalled = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
    check_eq("f3_011_err", 32'(resp_err), 32'd1);
    check_eq("f3_011_rdata", resp_rdata, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(1) == 1, 3'($urandom_range(7)),
           $urandom, $urandom, $urandom_range(2) != 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that sits between the execute stage and four byte-wide `dmem` banks (lane i holds byte i of each word). It accepts RISC-V load/store requests over a valid/ready handshake. For each request it drives the shared bank address, per-lane write enables and lane-replicated write data. One cycle later it aligns and sign- or zero-extends the bank read data into a completion response, and it buffers that response when the consumer stalls.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access width/sign:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu;
  - stores: 000 sb, 001 sh, 010 sw.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  completion present.
- `resp_ready`  in  1  consumer takes completion.
- `resp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `resp_err`  out  1  illegal funct3 or (when enabled) misaligned access.
- `mem_addr`  out  32  bank address; equals `req_addr`, banks use [5:2].
- `mem_we`  out  4  per-lane write enable.
- `mem_wr_data`  out  32  lane i = bits [8i+7:8i].
- `mem_rd_data`  in  32  lane read data, valid the cycle after address presentation.

## Operation
- States:
  - IDLE: no completion outstanding.
  - RESP: `resp_valid`=1, data formatted live from `mem_rd_data`.
  - HOLD: `resp_valid`=1, data from capture register.
- Accept: `req_valid & req_ready` in cycle T goes to RESP at T+1. Latched: `req_we`, funct3, `addr[1:0]`, error flag.
- RESP:
  - `resp_ready`=1: go to IDLE, or stay in RESP if a new request is accepted in the same cycle.
  - `resp_ready`=0: capture the formatted rdata/err, go to HOLD.
- HOLD: `resp_ready`=1 goes to IDLE.
- `req_ready` = `rst_n` & (state==IDLE | (state==RESP & `resp_ready`)).
- Store lanes (combinational in accept cycle only; `mem_we`=0 otherwise):
  - sb: `mem_we` = 0001 << addr[1:0], byte replicated to all lanes.
  - sh: `mem_we` = 0011 << (2·addr[1]), halfword replicated to both halves.
  - sw: `mem_we`=1111, data as-is.
- Load format:
  - lb/lbu: lane addr[1:0], sign-/zero-extended.
  - lh/lhu: lanes {2a+1, 2a} with a=addr[1], sign-/zero-extended.
  - lw: all lanes.
- Illegal funct3 (011, 110, 111 for loads; any with bit 2 set for stores): `mem_we`=0, `resp_err`=1, `resp_rdata`=0.
- Stores complete with `resp_rdata`=0, `resp_err`=0 unless an error applies.

## Timing
- Reset values: `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `req_ready`=0, `mem_we`=0, state IDLE, capture register 0.
- Load latency: accept at T, `resp_valid` and data at T+1. Store bank write commits at the rising edge ending T.
- Throughput: one request per cycle while `resp_ready`=1. At most one bubble after each stalled response.
- `mem_addr` follows `req_addr` in every cycle. HOLD data never depends on `mem_rd_data`.
- `rst_n` falling mid-transaction: the pending completion is dropped and no write is issued during reset. After release the block restarts in IDLE.
- Simultaneous accept and response drain in RESP: the old response retires and the new response appears at T+1.

## Configuration
- `DMEM_LSU_MISALIGN_TRAP_EN` defined:
  - misaligned lh/lhu/sh (addr[0]=1) or lw/sw (addr[1:0]≠0) gives `mem_we`=0, `resp_err`=1, `resp_rdata`=0.
- Undefined:
  - misaligned low bits are ignored: halfword uses addr[1] only, word uses lanes 0-3.
  - `resp_err` is asserted only for illegal funct3.

## Test plan
- Store sw addr 0x04 data 0xDEADBEEF, then lw 0x04 → `mem_we`=1111 at accept; response at T+1 with 0xDEADBEEF, err 0.
- sb 0x0B data 0x80, then lb 0x0B and lbu 0x0B → `mem_we`=1000, lane 3 = 0x80; rdata 0xFFFFFF80 then 0x00000080.
- sh 0x06 data 0x8001, then lh and lhu 0x06 → `mem_we`=1100; rdata 0xFFFF8001 then 0x00008001.
- Back-to-back loads with `resp_ready`=0 for 3 cycles after first → `req_ready` low, first response held stable, second issued after drain, no data loss.
- lw 0x05:
  - with the macro: err 1, rdata 0, no write for sw 0x05;
  - without the macro: rdata equals word at 0x04, err 0.
- Assert `rst_n` low in RESP → `resp_valid` 0 immediately; funct3 011 load after release → err 1, rdata 0.
